mux4_rr_sequencer: RTL and testbench

Round-robin scheduler that sits directly upstream of the 8-bit 4-to-1 data mux and drives its 2-bit `select`. Four requesters present bytes on the mux inputs `a`..`d` and raise a request. The sequencer picks one fairly, holds `select` stable, and handshakes the mux output to a single downstream sink with valid/ready. It also acknowledges the winning requester and counts completed transfers.

---
 rtl/mux4_rr_sequencer_if.sv | 30 +++
 rtl/mux4_rr_sequencer.sv | 101 ++++++++++
 tb/tb_mux4_rr_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mux4_rr_sequencer_if.sv
// Handshake bundle between the round-robin sequencer, its four requesters,
// the 4-to-1 data mux select and the downstream sink.
interface mux4_rr_sequencer_if #(
   parameter int CNT_WIDTH = 16
);
   logic [3:0]           req;
   logic [1:0]           select;
   logic                 out_valid;
   logic                 sink_ready;
   logic [3:0]           grant;
   logic [CNT_WIDTH-1:0] xfer_count;

   modport master (
      input  req,
      input  sink_ready,
      output select,
      output out_valid,
      output grant,
      output xfer_count
   );

   modport slave (
      output req,
      output sink_ready,
      input  select,
      input  out_valid,
      input  grant,
      input  xfer_count
   );
endinterface

// File: rtl/mux4_rr_sequencer.sv
// Round-robin scheduler driving the 2-bit select of an 8-bit 4-to-1 mux and
// handshaking the selected byte to a single valid/ready sink.
module mux4_rr_sequencer #(
   parameter int NUM_REQ   = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   mux4_rr_sequencer_if.master   bus
);
   localparam int SEL_W = $clog2(NUM_REQ);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   logic [0:0]           state_q, state_d;
   logic [SEL_W-1:0]     select_q, select_d;
   logic [SEL_W-1:0]     last_q, last_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;

   logic                 out_valid;
   logic                 xfer;
   logic [NUM_REQ-1:0]   grant;
   logic [NUM_REQ-1:0]   masked_req;
   logic [SEL_W:0]       pick_req;
   logic [SEL_W:0]       pick_masked;

   // Returns {found, index}; scans last+1, last+2, last+3, last (mod 4).
   function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] vec,
                                              input logic [SEL_W-1:0]   last);
      logic [SEL_W:0]   res;
      logic [SEL_W-1:0] idx;
      res = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = last + SEL_W'(k);
         if (vec[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   always_comb begin
      out_valid   = (state_q == HOLD);
      xfer        = out_valid & bus.sink_ready;
      grant       = xfer ? (NUM_REQ'(1) << select_q) : '0;
      // The consumed byte's req is still high this cycle, so mask it out.
      masked_req  = bus.req & ~grant;
      pick_req    = rr_pick(bus.req, last_q);
      pick_masked = rr_pick(masked_req, select_q);

      state_d  = state_q;
      select_d = select_q;
      last_d   = last_q;
      count_d  = count_q;

      case (state_q)
         IDLE: begin
            if (pick_req[SEL_W]) begin
               select_d = pick_req[SEL_W-1:0];
               state_d  = HOLD;
            end
         end
         HOLD: begin
            if (xfer) begin
               last_d  = select_q;
               count_d = count_q + CNT_WIDTH'(1);
               if (pick_masked[SEL_W]) begin
                  select_d = pick_masked[SEL_W-1:0];
               end else begin
                  state_d = IDLE;
               end
            end else if (!bus.req[select_q]) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         select_q <= '0;
         last_q   <= SEL_W'(NUM_REQ - 1);
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         select_q <= select_d;
         last_q   <= last_d;
         count_q  <= count_d;
      end
   end

   assign bus.select     = select_q;
   assign bus.out_valid  = out_valid;
   assign bus.grant      = grant;
   assign bus.xfer_count = count_q;
endmodule

// File: tb/tb_mux4_rr_sequencer.sv
// Directed-vector bench for mux4_rr_sequencer: a 16-bit counter instance and a
// 4-bit counter instance share clock, reset and stimulus.
module tb_mux4_rr_sequencer;
   logic       clk;
   logic       reset;
   logic [3:0] req_r;
   logic       rdy_r;
   int         vectors;
   int         miscompares;

   mux4_rr_sequencer_if #(.CNT_WIDTH(16)) bus16 ();
   mux4_rr_sequencer_if #(.CNT_WIDTH(4))  bus4 ();

   assign bus16.req        = req_r;
   assign bus16.sink_ready = rdy_r;
   assign bus4.req         = req_r;
   assign bus4.sink_ready  = rdy_r;

   mux4_rr_sequencer #(.NUM_REQ(4), .CNT_WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus16)
   );

   mux4_rr_sequencer #(.NUM_REQ(4), .CNT_WIDTH(4)) dut_narrow (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      if (obs != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge; outputs settle 1 ns later.
   task automatic step(input logic r, input logic [3:0] q, input logic s);
      @(negedge clk);
      reset = r;
      req_r = q;
      rdy_r = s;
      #1;
      $display("t=%0t rst=%0b req=%b rdy=%0b | sel=%0d vld=%0b gnt=%b cnt=%0d cnt4=%0d",
               $time, r, q, s, bus16.select, bus16.out_valid, bus16.grant,
               bus16.xfer_count, bus4.xfer_count);
   endtask

   task automatic expect_out(input string tag, input int sel, input int vld,
                             input int gnt, input int cnt);
      chk({tag, ".select"},     int'(bus16.select),     sel);
      chk({tag, ".out_valid"},  int'(bus16.out_valid),  vld);
      chk({tag, ".grant"},      int'(bus16.grant),      gnt);
      chk({tag, ".xfer_count"}, int'(bus16.xfer_count), cnt);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      req_r       = 4'b0000;
      rdy_r       = 1'b0;

      // Reset state
      step(1'b1, 4'b0000, 1'b0);
      step(1'b0, 4'b0000, 1'b0);
      expect_out("reset", 0, 0, 0, 0);
      chk("reset.cnt4", int'(bus4.xfer_count), 0);

      // Single request on c; sink_ready has no effect while idle
      step(1'b0, 4'b0100, 1'b1);
      expect_out("single.t0", 0, 0, 0, 0);
      step(1'b0, 4'b0100, 1'b1);
      expect_out("single.t1", 2, 1, 4'b0100, 0);
      step(1'b0, 4'b0000, 1'b1);
      expect_out("single.t2", 2, 0, 0, 1);

      // Full contention from a fresh reset: 0,1,2,3,0,1,2,3 with no bubbles
      step(1'b1, 4'b0000, 1'b0);
      step(1'b0, 4'b1111, 1'b1);
      expect_out("full.pre", 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 4'b1111, 1'b1);
         expect_out($sformatf("full.%0d", i), i % 4, 1, 1 << (i % 4), i);
      end
      step(1'b0, 4'b0000, 1'b0);
      expect_out("full.end", 0, 1, 0, 8);
      chk("full.cnt4", int'(bus4.xfer_count), 8);

      // Backpressure: last=3 so requester 0 wins and stalls for 5 cycles
      step(1'b0, 4'b0011, 1'b0);
      chk("bp.idle.out_valid", int'(bus16.out_valid), 0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 4'b0011, 1'b0);
         expect_out($sformatf("bp.stall%0d", i), 0, 1, 0, 8);
      end
      step(1'b0, 4'b0011, 1'b1);
      expect_out("bp.g0", 0, 1, 4'b0001, 8);
      step(1'b0, 4'b0010, 1'b1);
      expect_out("bp.g1", 1, 1, 4'b0010, 9);
      step(1'b0, 4'b0000, 1'b0);
      expect_out("bp.end", 1, 0, 0, 10);

      // Mask after grant: a lone request yields exactly one transfer
      step(1'b0, 4'b0010, 1'b1);
      expect_out("mask.pre", 1, 0, 0, 10);
      step(1'b0, 4'b0010, 1'b1);
      expect_out("mask.g", 1, 1, 4'b0010, 10);
      step(1'b0, 4'b0000, 1'b1);
      expect_out("mask.after", 1, 0, 0, 11);
      step(1'b0, 4'b0000, 1'b1);
      expect_out("mask.after2", 1, 0, 0, 11);

      // Abort: last=1, hold on requester 3, drop its req while stalled
      step(1'b0, 4'b1000, 1'b0);
      step(1'b0, 4'b1000, 1'b0);
      expect_out("abort.hold", 3, 1, 0, 11);
      step(1'b0, 4'b0000, 1'b0);
      expect_out("abort.drop", 3, 1, 0, 11);
      step(1'b0, 4'b1001, 1'b0);
      expect_out("abort.idle", 3, 0, 0, 11);
      // last is still 1, so search 2,3,0 picks 3 ahead of 0
      step(1'b0, 4'b1001, 1'b1);
      expect_out("abort.g3", 3, 1, 4'b1000, 11);
      step(1'b0, 4'b0001, 1'b1);
      expect_out("abort.g0", 0, 1, 4'b0001, 12);
      step(1'b0, 4'b0000, 1'b0);
      expect_out("abort.end", 0, 0, 0, 13);

      // Reset mid-HOLD overrides a transfer in the same cycle
      step(1'b0, 4'b0100, 1'b0);
      step(1'b1, 4'b0100, 1'b1);
      expect_out("rst.hold", 2, 1, 4'b0100, 13);
      step(1'b0, 4'b0000, 1'b0);
      expect_out("rst.after", 0, 0, 0, 0);
      chk("rst.after.cnt4", int'(bus4.xfer_count), 0);

      // Counter wrap on the 4-bit instance: 15 -> 0 -> 1
      step(1'b0, 4'b1111, 1'b1);
      chk("wrap.pre.out_valid", int'(bus16.out_valid), 0);
      for (int i = 0; i < 18; i++) begin
         step(1'b0, 4'b1111, 1'b1);
         chk($sformatf("wrap.%0d.select", i), int'(bus4.select), i % 4);
         chk($sformatf("wrap.%0d.grant", i), int'(bus4.grant), 1 << (i % 4));
         chk($sformatf("wrap.%0d.cnt4", i), int'(bus4.xfer_count), i % 16);
         chk($sformatf("wrap.%0d.cnt16", i), int'(bus16.xfer_count), i);
      end
      step(1'b0, 4'b0000, 1'b0);
      chk("wrap.end.cnt4", int'(bus4.xfer_count), 2);
      step(1'b0, 4'b0000, 1'b0);
      chk("wrap.end.out_valid", int'(bus16.out_valid), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
